square_renderer: RTL and testbench

Pixel-colour generator for the OLED path; it draws what the green-square mover computes. It consumes the mover's `current_x`/`current_y`, latches them once per frame to prevent tearing, and walks its own column/row scan in step with the OLED driver's pixel strobes. For each pixel it emits an RGB565 word showing the 9×9 green square, the red wall region and a black background, and it blinks the wall while the square is pressed against it.

---
 rtl/oled_pkg.sv | 28 ++
 rtl/square_renderer_if.sv | 20 ++
 rtl/pixel_scan_counter.sv | 46 ++++
 rtl/square_renderer.sv | 98 +++++++++
 tb/tb_square_renderer.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/oled_pkg.sv
// Geometry, colours and helpers shared by the OLED square mover and renderer.
package oled_pkg;

    localparam int SCREEN_W  = 96;
    localparam int SCREEN_H  = 64;
    localparam int SQUARE_SZ = 9;
    localparam int WALL_COL  = 65;
    localparam int WALL_ROW  = 30;

    localparam logic [15:0] EN_CODE   = 16'b1000001010101101;
    localparam logic [15:0] COL_GREEN = 16'h07E0;
    localparam logic [15:0] COL_RED   = 16'hF800;
    localparam logic [15:0] COL_BLACK = 16'h0000;

    localparam logic [6:0] RST_SX = 7'd0;
    localparam logic [5:0] RST_SY = 6'd54;

    // Widened to 8 bits so x+9 cannot wrap back under the wall column.
    function automatic logic wall_contact(input logic [6:0] x, input logic [5:0] y);
        logic [7:0] right;
        logic [7:0] top;
        right = {1'b0, x} + 8'(SQUARE_SZ);
        top   = {2'b00, y};
        return ((right == 8'(WALL_COL)) && (top < 8'(WALL_ROW))) ||
               ((top == 8'(WALL_ROW)) && (right > 8'(WALL_COL)));
    endfunction

endpackage

// File: rtl/square_renderer_if.sv
// Pixel handshake between the OLED driver (master) and the square renderer (slave).
interface square_renderer_if;

    logic        frame_begin;
    logic        sample_pixel;
    logic [15:0] oled_data;

    modport master (
        output frame_begin,
        output sample_pixel,
        input  oled_data
    );

    modport slave (
        input  frame_begin,
        input  sample_pixel,
        output oled_data
    );

endinterface

// File: rtl/pixel_scan_counter.sv
// Raster column/row counter tracking which pixel the OLED driver samples next.
module pixel_scan_counter
    import oled_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       restart_i,
    input  logic       advance_i,
    output logic [6:0] col_o,
    output logic [5:0] row_o
);

    localparam logic [6:0] COL_LAST = 7'(SCREEN_W - 1);
    localparam logic [5:0] ROW_LAST = 6'(SCREEN_H - 1);

    logic [6:0] col_q, col_d;
    logic [5:0] row_q, row_d;

    // col_o/row_o name the pixel a strobe in this cycle renders; a restart
    // in the same cycle forces it to (0,0).
    always_comb begin
        col_o = restart_i ? 7'd0 : col_q;
        row_o = restart_i ? 6'd0 : row_q;
        col_d = col_o;
        row_d = row_o;
        if (advance_i) begin
            if (col_o == COL_LAST) begin
                col_d = 7'd0;
                row_d = (row_o == ROW_LAST) ? 6'd0 : row_o + 6'd1;
            end else begin
                col_d = col_o + 7'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            col_q <= 7'd0;
            row_q <= 6'd0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/square_renderer.sv
// Renders the green square, red wall and black background as RGB565 pixels,
// using a position latched once per frame and blinking the wall on contact.
module square_renderer
    import oled_pkg::*;
#(
    parameter int BLINK_BIT = 3
) (
    input  logic               clock_25Mhz,
    input  logic               reset_n,
    square_renderer_if.slave   bus,
    input  logic [6:0]         current_x,
    input  logic [5:0]         current_y,
    input  logic [15:0]        switch,
    output logic               contact
);

    logic [6:0]  col;
    logic [5:0]  row;

    logic [6:0]  sx_q, sx_d;
    logic [5:0]  sy_q, sy_d;
    logic [3:0]  frame_cnt_q, frame_cnt_d;
    logic        contact_q, contact_d;
    logic [15:0] oled_q, oled_d;

    logic        en;
    logic        in_square;
    logic        in_wall;
    logic [7:0]  col8, row8, sx8, sy8;
    logic [15:0] pix_colour;

    pixel_scan_counter u_scan (
        .clk_i     (clock_25Mhz),
        .rst_ni    (reset_n),
        .restart_i (bus.frame_begin),
        .advance_i (bus.sample_pixel),
        .col_o     (col),
        .row_o     (row)
    );

    // Next-state values double as the render view, so a strobe coinciding
    // with frame_begin already sees the new frame's position and blink phase.
    always_comb begin
        sx_d        = sx_q;
        sy_d        = sy_q;
        frame_cnt_d = frame_cnt_q;
        contact_d   = contact_q;
        if (bus.frame_begin) begin
            sx_d        = current_x;
            sy_d        = current_y;
            frame_cnt_d = frame_cnt_q + 4'd1;
            contact_d   = wall_contact(current_x, current_y);
        end
    end

    assign en   = (switch == EN_CODE);
    assign col8 = {1'b0, col};
    assign row8 = {2'b00, row};
    assign sx8  = {1'b0, sx_d};
    assign sy8  = {2'b00, sy_d};

    assign in_square = (col8 >= sx8) && (col8 <= sx8 + 8'(SQUARE_SZ - 1)) &&
                       (row8 >= sy8) && (row8 <= sy8 + 8'(SQUARE_SZ - 1));
    assign in_wall   = (col8 >= 8'(WALL_COL)) && (row8 < 8'(WALL_ROW));

    always_comb begin
        pix_colour = COL_BLACK;
        if (!en) begin
            pix_colour = COL_BLACK;
        end else if (in_square) begin
            pix_colour = COL_GREEN;
        end else if (in_wall) begin
            pix_colour = (contact_d && frame_cnt_d[BLINK_BIT]) ? COL_BLACK : COL_RED;
        end
    end

    assign oled_d = bus.sample_pixel ? pix_colour : oled_q;

    always_ff @(posedge clock_25Mhz or negedge reset_n) begin
        if (!reset_n) begin
            sx_q        <= RST_SX;
            sy_q        <= RST_SY;
            frame_cnt_q <= 4'd0;
            contact_q   <= 1'b0;
            oled_q      <= COL_BLACK;
        end else begin
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            frame_cnt_q <= frame_cnt_d;
            contact_q   <= contact_d;
            oled_q      <= oled_d;
        end
    end

    assign bus.oled_data = oled_q;
    assign contact       = contact_q;

endmodule

// File: tb/tb_square_renderer.sv
// Scoreboard bench for square_renderer: a raster-index reference model queues
// the expected colour of every strobe, compared one cycle later.
module tb_square_renderer;

    logic        clock_25Mhz = 1'b0;
    logic        reset_n     = 1'b0;
    logic [6:0]  current_x   = 7'd0;
    logic [5:0]  current_y   = 6'd0;
    logic [15:0] switch      = 16'h82AD;
    logic        contact;

    square_renderer_if bus ();

    square_renderer #(.BLINK_BIT(3)) dut (
        .clock_25Mhz (clock_25Mhz),
        .reset_n     (reset_n),
        .bus         (bus),
        .current_x   (current_x),
        .current_y   (current_y),
        .switch      (switch),
        .contact     (contact)
    );

    always #20 clock_25Mhz = ~clock_25Mhz;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state, indexed linearly over the 96x64 raster.
    int m_sx, m_sy, m_fcnt, m_p;
    bit m_contact;
    logic [15:0] exp_q[$];
    string       tag_q[$];

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [15:0] model_pix(input int p);
        int c, r;
        c = p % 96;
        r = p / 96;
        if (switch !== 16'h82AD) return 16'h0000;
        if (c >= m_sx && c <= m_sx + 8 && r >= m_sy && r <= m_sy + 8) return 16'h07E0;
        if (c >= 65 && r < 30) return (m_contact && ((m_fcnt & 8) != 0)) ? 16'h0000 : 16'hF800;
        return 16'h0000;
    endfunction

    task automatic model_reset();
        m_sx = 0; m_sy = 54; m_fcnt = 0; m_p = 0; m_contact = 1'b0;
        exp_q.delete();
        tag_q.delete();
    endtask

    // One clock: check last strobe's output, drive this cycle, advance model.
    task automatic step(input bit fb, input bit sp, input bit use_k = 1'b0,
                        input logic [15:0] k = 16'h0000, input string tag = "pix");
        logic [15:0] e;
        string t;
        @(negedge clock_25Mhz);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            chk(t, bus.oled_data, e);
        end
        chk("contact", {15'b0, contact}, {15'b0, m_contact});
        bus.frame_begin  = fb;
        bus.sample_pixel = sp;
        if (fb) begin
            m_sx      = current_x;
            m_sy      = current_y;
            m_fcnt    = (m_fcnt + 1) % 16;
            m_contact = ((current_x + 9 == 65) && (current_y < 30)) ||
                        ((current_y == 30) && (current_x + 9 > 65));
            m_p       = 0;
        end
        if (sp) begin
            exp_q.push_back(use_k ? k : model_pix(m_p));
            tag_q.push_back(tag);
            m_p = (m_p + 1) % 6144;
        end
        @(posedge clock_25Mhz);
        #1;
        bus.frame_begin  = 1'b0;
        bus.sample_pixel = 1'b0;
    endtask

    task automatic adv_to(input int c, input int r);
        int tgt;
        tgt = r * 96 + c;
        while (m_p != tgt) step(1'b0, 1'b1);
    endtask

    task automatic spot(input logic [15:0] k, input string tag);
        step(1'b0, 1'b1, 1'b1, k, tag);
    endtask

    initial begin
        bus.frame_begin  = 1'b0;
        bus.sample_pixel = 1'b0;
        model_reset();
        #1;
        chk("reset_oled", bus.oled_data, 16'h0000);
        chk("reset_contact", {15'b0, contact}, 16'h0000);
        repeat (2) @(negedge clock_25Mhz);
        reset_n = 1'b1;

        // First frame straight out of reset: square at (0,54).
        adv_to(70, 10); spot(16'hF800, "first_wall");
        adv_to(0, 54);  spot(16'h07E0, "first_sq_tl");
        adv_to(9, 54);  spot(16'h0000, "first_right_of_sq");
        adv_to(8, 62);  spot(16'h07E0, "first_sq_br");
        step(1'b0, 1'b0);

        // Position latched at frame start; mid-frame moves are ignored.
        current_x = 7'd40; current_y = 6'd20;
        step(1'b1, 1'b0);
        current_x = 7'd50;
        adv_to(45, 20); spot(16'h07E0, "latch_old_pos");
        adv_to(52, 20); spot(16'h0000, "latch_new_pos_early");
        step(1'b1, 1'b0);
        adv_to(45, 20); spot(16'h0000, "latch_old_pos_next");
        adv_to(52, 20); spot(16'h07E0, "latch_new_pos_next");

        // Wall blink while in contact.
        current_x = 7'd56; current_y = 6'd10;
        for (int f = 0; f < 20; f++) begin
            step(1'b1, 1'b0);
            chk("blink_contact", {15'b0, contact}, 16'h0001);
            adv_to(80, 5);
            spot(((m_fcnt & 8) != 0) ? 16'h0000 : 16'hF800, "blink_wall");
        end
        step(1'b0, 1'b0);

        // Corner contact cases.
        current_x = 7'd60; current_y = 6'd30;
        step(1'b1, 1'b0);
        chk("corner_hit", {15'b0, contact}, 16'h0001);
        current_x = 7'd56; current_y = 6'd31;
        step(1'b1, 1'b0);
        chk("corner_miss", {15'b0, contact}, 16'h0000);

        // Disable mid-frame.
        step(1'b1, 1'b0);
        adv_to(70, 10); spot(16'hF800, "en_wall");
        switch = 16'h0000;
        adv_to(60, 35); spot(16'h0000, "dis_square");
        adv_to(70, 28); spot(16'h0000, "dis_wall");
        switch = 16'h82AD;
        step(1'b0, 1'b0);

        // Free-running scan wraps after a full frame of strobes.
        current_x = 7'd0; current_y = 6'd0;
        step(1'b1, 1'b0);
        for (int i = 0; i < 6144; i++) step(1'b0, 1'b1);
        spot(16'h07E0, "wrap_00");
        spot(16'h07E0, "wrap_10");

        // frame_begin coinciding with a strobe renders (0,0) with the new frame.
        current_x = 7'd20; current_y = 6'd20;
        step(1'b1, 1'b0);
        adv_to(10, 10);
        current_x = 7'd0; current_y = 6'd0;
        step(1'b1, 1'b1, 1'b1, 16'h07E0, "collide_00");
        spot(16'h07E0, "collide_10");
        adv_to(9, 0); spot(16'h0000, "collide_90");

        // Asynchronous reset mid-frame while green and in contact.
        current_x = 7'd56; current_y = 6'd10;
        step(1'b1, 1'b0);
        adv_to(60, 12); spot(16'h07E0, "pre_rst_sq");
        step(1'b0, 1'b0);
        #5 reset_n = 1'b0;
        #1;
        chk("rst_mid_oled", bus.oled_data, 16'h0000);
        chk("rst_mid_contact", {15'b0, contact}, 16'h0000);
        model_reset();
        repeat (2) @(negedge clock_25Mhz);
        reset_n = 1'b1;
        step(1'b0, 1'b1, 1'b1, 16'h0000, "post_rst_00");
        adv_to(0, 54); spot(16'h07E0, "post_rst_sq");
        adv_to(9, 54); spot(16'h0000, "post_rst_right");
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
